// File: rtl/gfx_mem_pkg.sv
// -----------------------------------------------------------------------------
// gfx_mem_pkg
// Shared definitions for the CPU/GPU work-RAM arbiter and the GPU/display MMIO
// register decoder:
//   - arb_state_t        : arbiter FSM states
//   - DEF_MEM_SIZE       : default work-RAM size in bytes (RAM window base 0)
//   - DEF_MMIO_SIZE      : default MMIO window size in bytes (placed after RAM)
//   - ERR_*              : bit positions inside the arbiter err_status vector
// -----------------------------------------------------------------------------
package gfx_mem_pkg;

    localparam int DEF_MEM_SIZE  = 24576;
    localparam int DEF_MMIO_SIZE = 512;

    localparam int ERR_W            = 3;
    localparam int ERR_CPU_RANGE    = 0;  // CPU address out of range or MMIO timeout
    localparam int ERR_GPU_RANGE    = 1;  // GPU address outside the RAM window
    localparam int ERR_GPU_OVERFLOW = 2;  // GPU pulse dropped, slot already full

    typedef enum logic [2:0] {
        ARB_IDLE,       // arbitrate between GPU slot and CPU request
        ARB_RAM_RD1,    // RAM is sampling the read address
        ARB_RAM_RD2,    // capture ram_rdata and complete
        ARB_MMIO_WAIT,  // hold the MMIO request until ready or timeout
        ARB_DONE        // issue the completion pulse
    } arb_state_t;

endpackage

// File: rtl/cpu_gpu_mem_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_gpu_mem_arbiter
// Shares one single-port synchronous work RAM between the picorv32 native
// memory port and the GPU read port. The GPU wins by default; a streak counter
// hands the RAM to a waiting CPU after GPU_MAX_STREAK consecutive GPU grants.
// CPU accesses above the RAM window go to a single MMIO port.
//
// Ports:
//   clk, resetn                     clock, asynchronous active-low reset
//   mem_valid/addr/wdata/wstrb      CPU request (wstrb == 0 means read)
//   mem_ready/mem_rdata             CPU one-cycle completion and read data
//   gpu_MemRead/gpu_MemAddr         GPU read request pulse and byte address
//   gpu_MemValid/gpu_MemData        GPU one-cycle completion and halfword
//   ram_en/we/addr/wdata, ram_rdata RAM macro port (read data one cycle later)
//   mmio_valid/addr/wdata/wstrb     MMIO request, addr is offset from MEM_SIZE
//   mmio_ready/mmio_rdata           MMIO completion and read data
//   err_status                      sticky error flags, cleared only by reset
// All outputs are registered.
// -----------------------------------------------------------------------------
module cpu_gpu_mem_arbiter
    import gfx_mem_pkg::*;
#(
    parameter int MEM_SIZE       = DEF_MEM_SIZE,
    parameter int MMIO_SIZE      = DEF_MMIO_SIZE,
    parameter int GPU_MAX_STREAK = 4,
    parameter int MMIO_TIMEOUT   = 255,
    parameter int RAM_AW         = $clog2(MEM_SIZE / 4)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    input  logic              gpu_MemRead,
    input  logic [31:0]       gpu_MemAddr,
    output logic [15:0]       gpu_MemData,
    output logic              gpu_MemValid,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    output logic              mmio_valid,
    output logic [31:0]       mmio_addr,
    output logic [31:0]       mmio_wdata,
    output logic [3:0]        mmio_wstrb,
    input  logic              mmio_ready,
    input  logic [31:0]       mmio_rdata,
    output logic [ERR_W-1:0]  err_status
);

    localparam logic [31:0] RAM_END  = 32'(MEM_SIZE);
    localparam logic [31:0] MMIO_END = 32'(MEM_SIZE + MMIO_SIZE);
    localparam int          STREAK_W = $clog2(GPU_MAX_STREAK + 1);
    localparam int          TIMER_W  = $clog2(MMIO_TIMEOUT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(GPU_MAX_STREAK);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(MMIO_TIMEOUT - 1);

    arb_state_t          state_q, state_d;
    logic                serve_gpu_q, serve_gpu_d;   // current access belongs to the GPU
    logic [31:0]         done_rdata_q, done_rdata_d; // CPU read data returned from DONE
    logic                gpu_pend_q, gpu_pend_d;
    logic [31:0]         gpu_addr_q, gpu_addr_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [ERR_W-1:0]    err_q, err_d;

    logic                mem_ready_q, mem_ready_d;
    logic [31:0]         mem_rdata_q, mem_rdata_d;
    logic [15:0]         gpu_data_q, gpu_data_d;
    logic                gpu_valid_q, gpu_valid_d;
    logic                ram_en_q, ram_en_d;
    logic [3:0]          ram_we_q, ram_we_d;
    logic [RAM_AW-1:0]   ram_addr_q, ram_addr_d;
    logic [31:0]         ram_wdata_q, ram_wdata_d;
    logic                mmio_valid_q, mmio_valid_d;
    logic [31:0]         mmio_addr_q, mmio_addr_d;
    logic [31:0]         mmio_wdata_q, mmio_wdata_d;
    logic [3:0]          mmio_wstrb_q, mmio_wstrb_d;

    logic cpu_req;
    logic cpu_in_ram;
    logic cpu_in_mmio;
    logic gpu_in_ram;

    // mem_ready_q is still high on the edge after a CPU completion, while the
    // CPU has not yet had a chance to drop or change mem_valid.
    assign cpu_req     = mem_valid && !mem_ready_q;
    assign cpu_in_ram  = mem_addr < RAM_END;
    assign cpu_in_mmio = !cpu_in_ram && (mem_addr < MMIO_END);
    assign gpu_in_ram  = gpu_addr_q < RAM_END;

    always_comb begin
        // NOTE: every _d starts from a default so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d      = state_q;
        serve_gpu_d  = serve_gpu_q;
        done_rdata_d = done_rdata_q;
        gpu_pend_d   = gpu_pend_q;
        gpu_addr_d   = gpu_addr_q;
        streak_d     = mem_valid ? streak_q : '0;
        timer_d      = timer_q;
        err_d        = err_q;
        mem_ready_d  = 1'b0;
        mem_rdata_d  = mem_rdata_q;
        gpu_data_d   = gpu_data_q;
        gpu_valid_d  = 1'b0;
        ram_en_d     = 1'b0;
        ram_we_d     = 4'b0000;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        mmio_valid_d = mmio_valid_q;
        mmio_addr_d  = mmio_addr_q;
        mmio_wdata_d = mmio_wdata_q;
        mmio_wstrb_d = mmio_wstrb_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (gpu_pend_q && !(cpu_req && streak_q == STREAK_MAX)) begin
                    serve_gpu_d = 1'b1;
                    if (mem_valid && streak_q != STREAK_MAX) begin
                        streak_d = streak_q + 1'b1;
                    end
                    if (gpu_in_ram) begin
                        ram_en_d   = 1'b1;
                        ram_addr_d = gpu_addr_q[RAM_AW+1:2];
                        state_d    = ARB_RAM_RD1;
                    end else begin
                        err_d[ERR_GPU_RANGE] = 1'b1;
                        state_d              = ARB_DONE;
                    end
                end else if (cpu_req) begin
                    serve_gpu_d  = 1'b0;
                    streak_d     = '0;
                    done_rdata_d = '0;
                    if (cpu_in_ram) begin
                        ram_en_d    = 1'b1;
                        ram_we_d    = mem_wstrb;
                        ram_addr_d  = mem_addr[RAM_AW+1:2];
                        ram_wdata_d = mem_wdata;
                        // Writes complete straight away; reads wait for the RAM.
                        state_d     = (mem_wstrb != 4'b0000) ? ARB_DONE : ARB_RAM_RD1;
                    end else if (cpu_in_mmio) begin
                        mmio_valid_d = 1'b1;
                        mmio_addr_d  = mem_addr - RAM_END;
                        mmio_wdata_d = mem_wdata;
                        mmio_wstrb_d = mem_wstrb;
                        timer_d      = '0;
                        state_d      = ARB_MMIO_WAIT;
                    end else begin
                        err_d[ERR_CPU_RANGE] = 1'b1;
                        state_d              = ARB_DONE;
                    end
                end
            end

            ARB_RAM_RD1: begin
                state_d = ARB_RAM_RD2;
            end

            ARB_RAM_RD2: begin
                if (serve_gpu_q) begin
                    gpu_valid_d = 1'b1;
                    gpu_data_d  = gpu_addr_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
                    gpu_pend_d  = 1'b0;
                end else begin
                    mem_ready_d = 1'b1;
                    mem_rdata_d = ram_rdata;
                end
                state_d = ARB_IDLE;
            end

            ARB_MMIO_WAIT: begin
                if (mmio_ready) begin
                    mmio_valid_d = 1'b0;
                    done_rdata_d = (mmio_wstrb_q == 4'b0000) ? mmio_rdata : '0;
                    state_d      = ARB_DONE;
                end else if (timer_q == TIMER_LAST) begin
                    // Force-complete so a dead MMIO target cannot hang the CPU.
                    mmio_valid_d         = 1'b0;
                    done_rdata_d         = '0;
                    err_d[ERR_CPU_RANGE] = 1'b1;
                    state_d              = ARB_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ARB_DONE: begin
                if (serve_gpu_q) begin
                    gpu_valid_d = 1'b1;
                    gpu_data_d  = '0;
                    gpu_pend_d  = 1'b0;
                end else begin
                    mem_ready_d = 1'b1;
                    mem_rdata_d = done_rdata_q;
                end
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // gpu_pend_d already reflects a slot freed on this edge, so a pulse
        // coinciding with the completion refills the slot without overflow.
        if (gpu_MemRead) begin
            if (gpu_pend_d) begin
                err_d[ERR_GPU_OVERFLOW] = 1'b1;
            end else begin
                gpu_pend_d = 1'b1;
                gpu_addr_d = gpu_MemAddr;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values computed before the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ARB_IDLE;
            serve_gpu_q  <= 1'b0;
            done_rdata_q <= '0;
            gpu_pend_q   <= 1'b0;
            gpu_addr_q   <= '0;
            streak_q     <= '0;
            timer_q      <= '0;
            err_q        <= '0;
            mem_ready_q  <= 1'b0;
            mem_rdata_q  <= '0;
            gpu_data_q   <= '0;
            gpu_valid_q  <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 4'b0000;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            mmio_valid_q <= 1'b0;
            mmio_addr_q  <= '0;
            mmio_wdata_q <= '0;
            mmio_wstrb_q <= 4'b0000;
        end else begin
            state_q      <= state_d;
            serve_gpu_q  <= serve_gpu_d;
            done_rdata_q <= done_rdata_d;
            gpu_pend_q   <= gpu_pend_d;
            gpu_addr_q   <= gpu_addr_d;
            streak_q     <= streak_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
            mem_ready_q  <= mem_ready_d;
            mem_rdata_q  <= mem_rdata_d;
            gpu_data_q   <= gpu_data_d;
            gpu_valid_q  <= gpu_valid_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            mmio_valid_q <= mmio_valid_d;
            mmio_addr_q  <= mmio_addr_d;
            mmio_wdata_q <= mmio_wdata_d;
            mmio_wstrb_q <= mmio_wstrb_d;
        end
    end

    assign mem_ready    = mem_ready_q;
    assign mem_rdata    = mem_rdata_q;
    assign gpu_MemData  = gpu_data_q;
    assign gpu_MemValid = gpu_valid_q;
    assign ram_en       = ram_en_q;
    assign ram_we       = ram_we_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wdata    = ram_wdata_q;
    assign mmio_valid   = mmio_valid_q;
    assign mmio_addr    = mmio_addr_q;
    assign mmio_wdata   = mmio_wdata_q;
    assign mmio_wstrb   = mmio_wstrb_q;
    assign err_status   = err_q;

endmodule
